fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_unit_if.sv | 33 +++
 rtl/fetch_queue.sv | 51 +++++
 rtl/fetch_unit.sv | 89 ++++++++
 tb/tb_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction fetch slice.
// No logic of its own; used by the fetch unit, its queue and the interface.
// Not applicable (no handshakes live here).
package fetch_pkg;

  localparam int ILEN    = 32;
  localparam int PC_STEP = 4;

  // Index width for a power-of-two table of n entries.
  function automatic int clog2(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch unit's memory, redirect and decode-side signals.
// Pure wiring, zero latency.
// Request side is valid/ready, response side has no backpressure, decode side is valid/ready.
interface fetch_unit_if #(parameter int XLEN = 32);
  import fetch_pkg::*;

  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [XLEN-1:0]  imem_req_addr;
  logic             imem_rsp_valid;
  logic [ILEN-1:0]  imem_rsp_data;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             inst_valid;
  logic             inst_ready;
  logic [ILEN-1:0]  inst_data;
  logic [XLEN-1:0]  inst_pc;

  // Fetch unit side.
  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, inst_ready
  );

  // Memory / decode / branch-unit side.
  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, inst_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// DEPTH-entry instruction FIFO with synchronous flush and an occupancy count.
// Write in cycle t is visible at the head in cycle t+1 (registered, no bypass).
// No internal backpressure: the caller guarantees push never lands on a full queue.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    push,
  input  logic [ILEN-1:0]         push_data,
  input  logic                    pop,
  output logic [ILEN-1:0]         head_data,
  output logic [clog2(DEPTH):0]   count
);

  localparam int AW = clog2(DEPTH);

  logic [ILEN-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  // Storage array write; a flush cancels the write in the same cycle.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; flush empties the queue outright.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Empty queue presents zero rather than stale storage.
  assign head_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch: issues word-aligned reads, queues in-order responses for decode.
// Response in cycle t reaches inst_valid in t+1; first request goes out the cycle after reset.
// Requests are credit-limited so queued plus live in-flight words never exceed DEPTH; decode stalls via inst_ready.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  localparam int CW = clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] head_pc;
  logic [XLEN-1:0] redirect_target;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   live;
  logic [CW-1:0]   rsp_dec;
  logic [CW-1:0]   q_count;
  logic [CW:0]     occupancy;
  logic            req_fire;
  logic            push;
  logic            pop;

  // Responses already owed to a flushed stream do not need queue space.
  assign live      = outstanding - drop;
  assign occupancy = {1'b0, q_count} + {1'b0, live};
  assign rsp_dec   = {{(CW-1){1'b0}}, bus.imem_rsp_valid};

  assign bus.imem_req_valid = !reset && !bus.redirect_valid &&
                              (occupancy < DEPTH_OCC) && (outstanding < DEPTH_CNT);
  assign bus.imem_req_addr  = fetch_pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  // A redirect flushes the queue, so neither a push nor a pop may land that cycle.
  assign push = bus.imem_rsp_valid && (drop == '0) && !bus.redirect_valid;
  assign pop  = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;

  assign redirect_target = {bus.redirect_pc[XLEN-1:2], 2'b00};

  assign bus.inst_valid = (q_count != '0);
  assign bus.inst_pc    = head_pc;

  // PCs, in-flight count and stale-response count; redirect overrides everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      head_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc    <= redirect_target;
      head_pc     <= redirect_target;
      outstanding <= outstanding - rsp_dec;
      drop        <= outstanding - rsp_dec;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + XLEN'(PC_STEP);
      if (pop)      head_pc  <= head_pc + XLEN'(PC_STEP);
      case ({req_fire, bus.imem_rsp_valid})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (bus.imem_rsp_valid && (drop != '0)) drop <= drop - 1'b1;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.redirect_valid),
    .push      (push),
    .push_data (bus.imem_rsp_data),
    .pop       (pop),
    .head_data (bus.inst_data),
    .count     (q_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomised checks of fetch_unit against an in-order PC/data scoreboard.
// Memory model has a selectable fixed latency; decode readiness and memory readiness are driven per test.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int              XLEN     = 32;
  localparam int              DEPTH    = 4;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;

  fetch_unit_if #(.XLEN(XLEN)) bus ();

  fetch_unit #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  // Memory model: fixed latency pipeline, cleared by the shared reset.
  int          lat = 1;
  logic [2:0]  tap;
  logic        pipe_v [8];
  logic [31:0] pipe_a [8];

  assign tap                = 3'(lat - 1);
  assign bus.imem_rsp_valid = pipe_v[tap];
  assign bus.imem_rsp_data  = mem_word(pipe_a[tap]);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_a[i] <= '0;
      end
    end else begin
      pipe_v[0] <= bus.imem_req_valid && bus.imem_req_ready;
      pipe_a[0] <= bus.imem_req_addr;
      for (int i = 1; i < 8; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
      end
    end
  end

  // Requests fired but whose response cycle has not yet completed.
  function automatic int inflight();
    int n = 0;
    for (int i = 0; i < lat; i++) n += int'(pipe_v[i]);
    return n;
  endfunction

  // Scoreboard: every accepted head must follow the expected sequential PC stream.
  logic [31:0] exp_pc;
  int pops = 0;
  int ovf  = 0;

  always @(negedge clk) begin
    if (reset) begin
      exp_pc = RESET_PC;
    end else if (bus.redirect_valid) begin
      exp_pc = bus.redirect_pc & ~32'h3;
    end else if (bus.inst_valid && bus.inst_ready) begin
      check("pop_pc",   64'(bus.inst_pc),   64'(exp_pc));
      check("pop_data", 64'(bus.inst_data), 64'(mem_word(exp_pc)));
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (!reset && dut.push && (int'(dut.q_count) == DEPTH)) ovf++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int p0;
  int inflight_t;
  bit seen;

  initial begin
    reset              = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b1;
    lat                = 1;
    repeat (3) @(posedge clk);
    #1;

    // Reset state.
    check("rst_req_valid",  64'(bus.imem_req_valid), 64'd0);
    check("rst_inst_valid", 64'(bus.inst_valid),     64'd0);
    check("rst_inst_data",  64'(bus.inst_data),      64'd0);
    check("rst_inst_pc",    64'(bus.inst_pc),        64'(RESET_PC));
    check("rst_req_addr",   64'(bus.imem_req_addr),  64'(RESET_PC));
    check("rst_outstanding", 64'(dut.outstanding),   64'd0);

    // Streaming with 1-cycle memory: request in cycle 0, head valid in cycle 2.
    reset = 1'b0;
    @(negedge clk);
    check("c0_req_valid",  64'(bus.imem_req_valid), 64'd1);
    check("c0_req_addr",   64'(bus.imem_req_addr),  64'(RESET_PC));
    check("c0_inst_valid", 64'(bus.inst_valid),     64'd0);
    @(negedge clk);
    check("c1_rsp_valid",  64'(bus.imem_rsp_valid), 64'd1);
    check("c1_inst_valid", 64'(bus.inst_valid),     64'd0);
    @(negedge clk);
    check("c2_inst_valid", 64'(bus.inst_valid),     64'd1);
    check("c2_inst_pc",    64'(bus.inst_pc),        64'(RESET_PC));
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("stream_valid", 64'(bus.inst_valid), 64'd1);
    end

    // Decode stall: queue fills to DEPTH, fetch stops, nothing in flight.
    step();
    bus.inst_ready = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("stall_inst_valid",  64'(bus.inst_valid),     64'd1);
    check("stall_req_valid",   64'(bus.imem_req_valid), 64'd0);
    check("stall_outstanding", 64'(dut.outstanding),    64'd0);
    check("stall_inflight",    64'(inflight()),         64'd0);
    check("stall_count",       64'(dut.q_count),        64'(DEPTH));
    check("stall_head_pc",     64'(bus.inst_pc),        64'(exp_pc));
    step();
    bus.inst_ready = 1'b1;
    p0 = pops;
    repeat (8) @(posedge clk);
    #1;
    check("drain_pops", 64'(pops - p0), 64'd8);

    // 3-cycle memory, redirect with two requests in flight.
    reset = 1'b1;
    lat   = 3;
    step();
    reset = 1'b0;
    step();
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    @(negedge clk);
    check("redir_no_req",      64'(bus.imem_req_valid), 64'd0);
    check("redir_outstanding", 64'(dut.outstanding),    64'd2);
    step();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_drop",       64'(dut.drop),           64'd2);
    check("redir_req_valid",  64'(bus.imem_req_valid), 64'd1);
    check("redir_req_addr",   64'(bus.imem_req_addr),  64'h100);
    check("redir_inst_valid", 64'(bus.inst_valid),     64'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.inst_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("redir_seen",     64'(seen),        64'd1);
    check("redir_first_pc", 64'(bus.inst_pc), 64'h100);

    // Redirect in the same cycle as a response and a pop; unaligned target.
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.imem_rsp_valid && bus.inst_valid) begin
        seen = 1'b1;
        break;
      end
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h203;
    inflight_t         = inflight();
    @(negedge clk);
    check("rr_found", 64'(seen), 64'd1);
    step();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    check("rr_count",      64'(dut.q_count),       64'd0);
    check("rr_inst_valid", 64'(bus.inst_valid),    64'd0);
    check("rr_drop",       64'(dut.drop),          64'(inflight_t - 1));
    check("rr_req_addr",   64'(bus.imem_req_addr), 64'h200);

    // Back-to-back redirects: the last one wins.
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h300;
    step();
    bus.redirect_pc    = 32'h406;
    step();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    check("b2b_req_addr",   64'(bus.imem_req_addr), 64'h404);
    check("b2b_inst_pc",    64'(bus.inst_pc),       64'h404);
    check("b2b_inst_valid", 64'(bus.inst_valid),    64'd0);
    repeat (20) step();
    check("b2b_progress", 64'(exp_pc >= 32'h410), 64'd1);

    // Random memory/decode readiness with occasional redirects.
    p0 = pops;
    for (int i = 0; i < 1000; i++) begin
      step();
      bus.imem_req_ready = 1'($urandom_range(0, 1));
      bus.inst_ready     = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 39) == 0);
      bus.redirect_pc    = 32'($urandom_range(0, 65535));
    end
    step();
    bus.imem_req_ready = 1'b1;
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b0;
    check("rand_progress", 64'((pops - p0) > 100), 64'd1);

    // Asynchronous reset mid-stream.
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.inst_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("pre_rst_valid", 64'(seen), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_req_valid",  64'(bus.imem_req_valid), 64'd0);
    check("arst_inst_valid", 64'(bus.inst_valid),     64'd0);
    check("arst_inst_data",  64'(bus.inst_data),      64'd0);
    check("arst_inst_pc",    64'(bus.inst_pc),        64'(RESET_PC));
    check("arst_req_addr",   64'(bus.imem_req_addr),  64'(RESET_PC));
    step();
    reset = 1'b0;
    @(negedge clk);
    check("restart_req_valid", 64'(bus.imem_req_valid), 64'd1);
    check("restart_req_addr",  64'(bus.imem_req_addr),  64'(RESET_PC));
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.inst_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("restart_seen", 64'(seen),        64'd1);
    check("restart_pc",   64'(bus.inst_pc), 64'(RESET_PC));
    repeat (10) step();

    check("no_overflow", 64'(ovf), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
